stack_control_unit: RTL

Multicycle control FSM for the stack CPU datapath. Decodes the instruction register and drives every enable and select of the PC, MSP and RSP incrementers, the dual-port memory stage and the ALU result register. Tracks main-stack and return-stack depth so underflow halts the machine instead of corrupting memory. Sits directly upstream of the datapath integration: its outputs feed the datapath, and `IROut`/ValA feed back into it.

---
 rtl/stack_control_unit.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/stack_control_unit.sv
// Multicycle control FSM for the stack CPU datapath: decodes IR and drives all enables
// and selects, tracking main/return stack depth so that an underflow halts the machine.
module stack_control_unit #(
    parameter int DEPTH_W = 8
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic        Run,
    input  logic [15:0] IR,
    input  logic        ValAZero,
    output logic        MSPWrite,
    output logic        MSPPop,
    output logic        RSPWrite,
    output logic        RSPPop,
    output logic        PCWrite,
    output logic        PCSource,
    output logic        PCAdd,
    output logic        ValAWrite,
    output logic        ValBWrite,
    output logic        IRWrite,
    output logic        ResWrite,
    output logic        MemRead1,
    output logic        MemRead2,
    output logic        MemWrite1,
    output logic        MemWrite2,
    output logic [1:0]  MemDst1,
    output logic [1:0]  MemDst2,
    output logic [2:0]  MemData,
    output logic [2:0]  ALUOp,
    output logic        Halted,
    output logic        Error
);

    typedef enum logic [4:0] {
        IDLE, FETCH, DECODE, PUSH, POPA, RDA, RDB, EXEC, WBACK,
        JUMP, CALL, RPOP, RRD, RJMP, BPOP, BRD, BTST, HALT
    } state_t;

    localparam logic [DEPTH_W-1:0] DEPTH_MAX = '1;

    state_t             state, state_nxt;
    logic               err_set;
    logic [DEPTH_W-1:0] mdepth, rdepth;

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state  <= IDLE;
            Error  <= 1'b0;
            mdepth <= '0;
            rdepth <= '0;
        end else begin
            state <= state_nxt;
            if (err_set)
                Error <= 1'b1;
            // Increments saturate silently; decrements are guarded by the DECODE underflow check.
            case (state)
                PUSH, WBACK:     if (mdepth != DEPTH_MAX) mdepth <= mdepth + 1'b1;
                POPA, RDA, BPOP: if (mdepth != '0) mdepth <= mdepth - 1'b1;
                CALL:            if (rdepth != DEPTH_MAX) rdepth <= rdepth + 1'b1;
                RPOP:            if (rdepth != '0) rdepth <= rdepth - 1'b1;
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        err_set   = 1'b0;
        case (state)
            IDLE:   if (Run) state_nxt = FETCH;
            FETCH:  state_nxt = DECODE;
            DECODE: begin
                case (IR[15:12])
                    4'h0: state_nxt = IDLE;
                    4'h1: state_nxt = PUSH;
                    4'h2: if (mdepth >= DEPTH_W'(2)) state_nxt = POPA;
                          else begin state_nxt = HALT; err_set = 1'b1; end
                    4'h3: state_nxt = JUMP;
                    4'h4: state_nxt = CALL;
                    4'h5: if (rdepth >= DEPTH_W'(1)) state_nxt = RPOP;
                          else begin state_nxt = HALT; err_set = 1'b1; end
                    4'h6: if (mdepth >= DEPTH_W'(1)) state_nxt = BPOP;
                          else begin state_nxt = HALT; err_set = 1'b1; end
                    4'hF: state_nxt = HALT;
                    default: begin state_nxt = HALT; err_set = 1'b1; end
                endcase
            end
            PUSH:   state_nxt = IDLE;
            POPA:   state_nxt = RDA;
            RDA:    state_nxt = RDB;
            RDB:    state_nxt = EXEC;
            EXEC:   state_nxt = WBACK;
            WBACK:  state_nxt = IDLE;
            JUMP:   state_nxt = IDLE;
            CALL:   state_nxt = IDLE;
            RPOP:   state_nxt = RRD;
            RRD:    state_nxt = RJMP;
            RJMP:   state_nxt = IDLE;
            BPOP:   state_nxt = BRD;
            BRD:    state_nxt = BTST;
            BTST:   state_nxt = IDLE;
            HALT:   state_nxt = HALT;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        MSPWrite  = 1'b0;
        MSPPop    = 1'b0;
        RSPWrite  = 1'b0;
        RSPPop    = 1'b0;
        PCWrite   = 1'b0;
        PCSource  = 1'b0;
        PCAdd     = 1'b0;
        ValAWrite = 1'b0;
        ValBWrite = 1'b0;
        IRWrite   = 1'b0;
        ResWrite  = 1'b0;
        MemRead1  = 1'b0;
        MemRead2  = 1'b0;
        MemWrite1 = 1'b0;
        MemWrite2 = 1'b0;
        MemDst1   = 2'd0;
        MemDst2   = 2'd0;
        MemData   = 3'd0;
        ALUOp     = 3'd0;
        Halted    = 1'b0;
        case (state)
            FETCH: begin MemRead1 = 1'b1; IRWrite = 1'b1; PCWrite = 1'b1; end
            PUSH:  begin MemWrite2 = 1'b1; MemData = 3'd2; MSPWrite = 1'b1; end
            POPA:  begin MSPWrite = 1'b1; MSPPop = 1'b1; end
            RDA:   begin MemRead2 = 1'b1; ValAWrite = 1'b1; MSPWrite = 1'b1; MSPPop = 1'b1; end
            RDB:   begin MemRead2 = 1'b1; ValBWrite = 1'b1; end
            EXEC:  begin ResWrite = 1'b1; ALUOp = IR[2:0]; end
            WBACK: begin MemWrite2 = 1'b1; MemData = 3'd1; MSPWrite = 1'b1; end
            JUMP:  begin PCWrite = 1'b1; PCAdd = 1'b1; end
            CALL: begin
                MemWrite2 = 1'b1; MemDst2 = 2'd1; MemData = 3'd0;
                RSPWrite = 1'b1; PCWrite = 1'b1; PCAdd = 1'b1;
            end
            RPOP:  begin RSPWrite = 1'b1; RSPPop = 1'b1; end
            RRD:   begin MemRead2 = 1'b1; MemDst2 = 2'd1; ValAWrite = 1'b1; end
            RJMP:  begin PCWrite = 1'b1; PCSource = 1'b1; end
            BPOP:  begin MSPWrite = 1'b1; MSPPop = 1'b1; end
            BRD:   begin MemRead2 = 1'b1; ValAWrite = 1'b1; end
            BTST:  begin PCWrite = ValAZero; PCAdd = ValAZero; end
            HALT:  Halted = 1'b1;
            default: ;
        endcase
    end

endmodule
